// File: rtl/pattern_merge_pipe_if.sv
// Handshake, pattern-operand and signature bus for pattern_merge_pipe.
// The block itself connects through the slave modport; the driving side uses master.
interface pattern_merge_pipe_if #(
    parameter int CH    = 4,
    parameter int SIG_W = 16,
    parameter int CNT_W = 8
);
    logic [CH-1:0]    in_a;
    logic [CH-1:0]    in_b;
    logic [CH-1:0]    in_c;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [CH-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sig_clear;
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_a, in_b, in_c, mode, in_valid, out_ready, sig_clear,
        input  in_ready, out_data, out_valid, sig, out_count
    );

    modport slave (
        input  in_a, in_b, in_c, mode, in_valid, out_ready, sig_clear,
        output in_ready, out_data, out_valid, sig, out_count
    );
endinterface

// File: rtl/pattern_merge_pipe.sv
// CH-channel AND/NOR pattern merge feeding a DEPTH-stage valid/ready pipeline,
// with every accepted output word folded into a Galois MISR and counted.
module pattern_merge_pipe #(
    parameter int               CH       = 4,
    parameter int               DEPTH    = 2,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] POLY     = 16'h1021,
    parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF,
    parameter int               CNT_W    = 8
) (
    input logic                 blif_clk_net,
    input logic                 blif_reset_net,
    pattern_merge_pipe_if.slave bus
);

    logic [CH-1:0]    w_p1372;
    logic [CH-1:0]    w_p1508;
    logic [CH-1:0]    w_p6147;
    logic [CH-1:0]    w_result;
    logic [DEPTH-1:0] w_load;
    logic             w_chain;
    logic             w_accept;
    logic             w_fire;
    logic [SIG_W-1:0] w_sigNext;

    logic [CH-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [SIG_W-1:0] r_sig;
    logic [CNT_W-1:0] r_count;

    always_comb begin
        w_p1372  = bus.in_a & bus.in_b;
        w_p1508  = bus.in_a & bus.in_b & ~bus.in_c;
        w_p6147  = (bus.in_a | bus.in_b) & ~bus.in_c;
        w_result = w_p1372;
        case (bus.mode)
            2'd0:    w_result = w_p1372;
            2'd1:    w_result = w_p1508;
            2'd2:    w_result = w_p6147;
            default: w_result = w_p1508 ^ w_p6147;
        endcase
    end

    // A stage may load when it is empty or when the stage after it can load;
    // the last stage frees up when downstream takes its word.
    always_comb begin
        w_chain = bus.out_ready;
        w_load  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_load[k] = ~r_valid[k] | w_chain;
            w_chain   = w_load[k];
        end
    end

    assign w_accept = bus.in_valid & w_load[0];

    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= w_accept;
                if (w_accept) begin
                    r_data[0] <= w_result;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_data[k] <= r_data[k-1];
                    end
                end
            end
        end
    end

    assign w_fire    = r_valid[DEPTH-1] & bus.out_ready;
    assign w_sigNext = (r_sig << 1) ^ (r_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(r_data[DEPTH-1]);

    // A clear wins over a coincident handshake; that word still leaves the pipe.
    always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
            r_sig   <= SIG_SEED;
            r_count <= '0;
        end else if (bus.sig_clear) begin
            r_sig   <= SIG_SEED;
            r_count <= '0;
        end else if (w_fire) begin
            r_sig   <= w_sigNext;
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_data  = r_data[DEPTH-1];
    assign bus.out_valid = r_valid[DEPTH-1];
    assign bus.sig       = r_sig;
    assign bus.out_count = r_count;

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Self-checking bench for pattern_merge_pipe: vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_pattern_merge_pipe;

    localparam int CH    = 4;
    localparam int DEPTH = 2;
    localparam int SIG_W = 16;
    localparam int CNT_W = 8;
    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] SEED = 16'hFFFF;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    pattern_merge_pipe_if #(.CH(CH), .SIG_W(SIG_W), .CNT_W(CNT_W)) bus ();

    pattern_merge_pipe #(
        .CH(CH), .DEPTH(DEPTH), .SIG_W(SIG_W), .POLY(POLY), .SIG_SEED(SEED), .CNT_W(CNT_W)
    ) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [1:0] mode;
        logic [3:0] expOut;
    } vector_t;

    typedef struct {
        logic [3:0] data;
        int         t;
    } entry_t;

    vector_t tbl [10];
    entry_t  q [$];
    int      cyc;
    int      mCnt;
    logic [15:0] mSig;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (time %0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                 input logic [1:0] m, input logic v, input logic rdy, input logic clr);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_c      = c;
        bus.mode      = m;
        bus.in_valid  = v;
        bus.out_ready = rdy;
        bus.sig_clear = clr;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        cyc  = 0;
        q.delete();
        mSig = SEED;
        mCnt = 0;
    endtask

    // Per-channel pattern rules evaluated bit by bit with boolean operators.
    function automatic logic [3:0] patternOf(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c, input logic [1:0] m);
        logic [3:0] r;
        logic       andBit, inhBit, orBit;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            andBit = a[i] && b[i];
            inhBit = a[i] && b[i] && !c[i];
            orBit  = (a[i] || b[i]) && !c[i];
            case (m)
                2'd0:    r[i] = andBit;
                2'd1:    r[i] = inhBit;
                2'd2:    r[i] = orBit;
                default: r[i] = inhBit != orBit;
            endcase
        end
        return r;
    endfunction

    function automatic logic [15:0] misrFold(input logic [15:0] s, input logic [3:0] d);
        int v;
        v = (int'(s) * 2) % 65536;
        if (int'(s) >= 32768) v = v ^ int'(POLY);
        v = v ^ int'(d);
        return v[15:0];
    endfunction

    // Oldest word reaches the output exactly DEPTH cycles after acceptance, as
    // nothing is ahead of it; occupancy below DEPTH or a taking sink frees the input.
    task automatic runModel(input int cycles, input int pValid, input int pReady, input int pClear);
        logic [3:0] a, b, c;
        logic [1:0] m;
        logic       v, rdy, clr, expValid, expReady;
        v = 1'b0; a = '0; b = '0; c = '0; m = '0;
        for (int n = 0; n < cycles; n++) begin
            if (!v || $urandom_range(0, 99) < 100) begin
                if (!v) begin
                    v = ($urandom_range(0, 99) < pValid);
                    a = 4'($urandom);
                    b = 4'($urandom);
                    c = 4'($urandom);
                    m = 2'($urandom_range(0, 3));
                end
            end
            rdy = ($urandom_range(0, 99) < pReady);
            clr = ($urandom_range(0, 99) < pClear);
            applyStimulus(a, b, c, m, v, rdy, clr);
            #1;
            expValid = (q.size() > 0) && (cyc - q[0].t >= DEPTH);
            expReady = (q.size() < DEPTH) || rdy;
            checkOutput("rnd_out_valid", 32'(bus.out_valid), 32'(expValid));
            checkOutput("rnd_in_ready", 32'(bus.in_ready), 32'(expReady));
            checkOutput("rnd_sig", 32'(bus.sig), 32'(mSig));
            checkOutput("rnd_count", 32'(bus.out_count), 32'(mCnt % 256));
            if (expValid) checkOutput("rnd_out_data", 32'(bus.out_data), 32'(q[0].data));
            if (expValid && rdy) begin
                if (!clr) begin
                    mSig = misrFold(mSig, q[0].data);
                    mCnt = mCnt + 1;
                end
                void'(q.pop_front());
            end
            if (clr) begin
                mSig = SEED;
                mCnt = 0;
            end
            if (v && expReady) begin
                q.push_back('{data: patternOf(a, b, c, m), t: cyc});
                v = 1'b0;
            end
            nextCycle();
            cyc++;
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b0;

        tbl[0] = '{4'hF, 4'hA, 4'h3, 2'd0, 4'hA};
        tbl[1] = '{4'hF, 4'hA, 4'h3, 2'd1, 4'h8};
        tbl[2] = '{4'hF, 4'hA, 4'h3, 2'd2, 4'hC};
        tbl[3] = '{4'hF, 4'hA, 4'h3, 2'd3, 4'h4};
        tbl[4] = '{4'h0, 4'h0, 4'h0, 2'd2, 4'h0};
        tbl[5] = '{4'h5, 4'hA, 4'h0, 2'd2, 4'hF};
        tbl[6] = '{4'h5, 4'hA, 4'h0, 2'd3, 4'hF};
        tbl[7] = '{4'hF, 4'hF, 4'hF, 2'd1, 4'h0};
        tbl[8] = '{4'hF, 4'hF, 4'h0, 2'd3, 4'h0};
        tbl[9] = '{4'hC, 4'h6, 4'h1, 2'd0, 4'h4};

        // Reset state
        doReset();
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_sig", 32'(bus.sig), 32'hFFFF);
        checkOutput("reset_count", 32'(bus.out_count), 32'd0);
        checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);

        // Vector table streamed back-to-back, each result DEPTH cycles later
        for (int i = 0; i < 10 + DEPTH; i++) begin
            if (i < 10) applyStimulus(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].mode, 1'b1, 1'b1, 1'b0);
            else        applyStimulus(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
            #1;
            if (i >= DEPTH) begin
                checkOutput("tbl_out_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("tbl_out_data", 32'(bus.out_data), 32'(tbl[i-DEPTH].expOut));
            end else begin
                checkOutput("tbl_latency_valid", 32'(bus.out_valid), 32'd0);
            end
            nextCycle();
        end

        // Single word from reset: signature FFFF -> EFD5, count 1
        doReset();
        applyStimulus(4'hF, 4'hA, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("single_in_ready", 32'(bus.in_ready), 32'd1);
        nextCycle();
        applyStimulus(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("single_early_valid", 32'(bus.out_valid), 32'd0);
        nextCycle();
        checkOutput("single_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("single_out_data", 32'(bus.out_data), 32'hA);
        nextCycle();
        checkOutput("single_sig", 32'(bus.sig), 32'hEFD5);
        checkOutput("single_count", 32'(bus.out_count), 32'd1);

        // Fill with the sink stalled, then drain in order
        doReset();
        applyStimulus(4'hF, 4'hF, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("fill_ready0", 32'(bus.in_ready), 32'd1);
        nextCycle();
        applyStimulus(4'h3, 4'h3, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("fill_ready1", 32'(bus.in_ready), 32'd1);
        nextCycle();
        applyStimulus(4'h5, 4'h5, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("fill_full_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("fill_stall_data", 32'(bus.out_data), 32'hF);
        nextCycle();
        #1;
        checkOutput("fill_hold_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("fill_hold_data", 32'(bus.out_data), 32'hF);
        checkOutput("fill_hold_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(4'h5, 4'h5, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("fill_release_ready", 32'(bus.in_ready), 32'd1);
        nextCycle();
        applyStimulus(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("drain_w2", 32'(bus.out_data), 32'h3);
        checkOutput("drain_w2_valid", 32'(bus.out_valid), 32'd1);
        nextCycle();
        checkOutput("drain_w3", 32'(bus.out_data), 32'h5);
        checkOutput("drain_w3_valid", 32'(bus.out_valid), 32'd1);
        nextCycle();
        checkOutput("drain_empty", 32'(bus.out_valid), 32'd0);
        checkOutput("drain_count", 32'(bus.out_count), 32'd3);

        // Clear coincident with a handshake
        doReset();
        applyStimulus(4'hF, 4'hA, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'hF, 4'hA, 4'h3, 2'd2, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("clr_pre_sig", 32'(bus.sig), 32'hEFD5);
        checkOutput("clr_pre_count", 32'(bus.out_count), 32'd1);
        applyStimulus(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("clr_word_data", 32'(bus.out_data), 32'hC);
        checkOutput("clr_word_valid", 32'(bus.out_valid), 32'd1);
        nextCycle();
        applyStimulus(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("clr_sig", 32'(bus.sig), 32'hFFFF);
        checkOutput("clr_count", 32'(bus.out_count), 32'd0);
        checkOutput("clr_word_left", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with two words in flight
        doReset();
        applyStimulus(4'hF, 4'hA, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'hF, 4'hF, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("rst_mid_valid_before", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_mid_sig", 32'(bus.sig), 32'hFFFF);
        checkOutput("rst_mid_count", 32'(bus.out_count), 32'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(4'hF, 4'hA, 4'h3, 2'd1, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("rst_after_ready", 32'(bus.in_ready), 32'd1);
        nextCycle();
        applyStimulus(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("rst_after_early", 32'(bus.out_valid), 32'd0);
        nextCycle();
        checkOutput("rst_after_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("rst_after_data", 32'(bus.out_data), 32'h8);

        // Randomized traffic against the reference model
        doReset();
        runModel(400, 70, 60, 3);

        // 256 full-rate transfers wrap the counter back to zero
        doReset();
        runModel(256 + DEPTH, 100, 100, 0);
        checkOutput("wrap_count", 32'(bus.out_count), 32'd0);
        checkOutput("wrap_model_count", 32'(mCnt), 32'd256);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pattern_merge_pipe.md
Name: pattern_merge_pipe

Overview:
- Parametrised successor to the flat pattern-merge netlists: CH parallel channels of the AND/NOR pattern cells, selectable by mode.
- Result passes through a DEPTH-stage valid/ready pipeline with backpressure.
- Every accepted output word is folded into a Galois MISR signature with a wrapping transaction counter, so merged-pattern benches get a compact self-check.
- Sits between the combinational pattern fabric and the bench scoreboard.

Parameters:
- CH, 4: channel count; width of in_a/in_b/in_c/out_data. Legal range 1..SIG_W.
- DEPTH, 2: pipeline stages, >=1.
- SIG_W, 16: signature width.
- POLY, 16'h1021: MISR feedback polynomial, SIG_W bits.
- SIG_SEED, 16'hFFFF: signature value after reset or clear.
- CNT_W, 8: output transaction counter width.

Ports:
- blif_clk_net  in  1  clock; all state on rising edge.
- blif_reset_net  in  1  asynchronous, active-high reset.
- in_a  in  CH  pattern operand A, per channel.
- in_b  in  CH  pattern operand B.
- in_c  in  CH  pattern operand C (inhibit).
- mode  in  2  pattern select; sampled with the input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word.
- out_data  out  CH  result from the last stage.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- sig_clear  in  1  synchronous clear of signature and counter.
- sig  out  SIG_W  MISR signature.
- out_count  out  CNT_W  accepted-output count, wraps.

Behaviour:
- Per channel i, combinational:
  - p1372 = a&b
  - p1508 = a&b&~c
  - p6147 = (a|b)&~c
- Mode mapping: 0 -> p1372; 1 -> p1508; 2 -> p6147; 3 -> p1508^p6147.
- Result is computed at input and captured into stage 0. Mode is not stored.
- Stage k holds data and valid. It loads from stage k-1 (stage 0 loads from input) when it is empty or its contents advance this cycle.
- The last stage advances when out_ready=1. Stage k<DEPTH-1 advances when stage k+1 can load.
- in_ready = ~valid[0] | adv[0] (combinational from out_ready through the chain). Input is accepted when in_valid & in_ready.
- Latency: word accepted in cycle t gives out_valid=1 in cycle t+DEPTH, provided out_ready held high. Throughput is 1 word/cycle with no bubbles.
- Stalled last stage: out_data and out_valid hold stable until out_ready=1. A full pipe deasserts in_ready in the same cycle.
- Bubbles: a stage not loaded with valid data clears its valid. Data registers may keep stale values.
- Output handshake when out_valid & out_ready:
  - sig <= ((sig<<1) ^ (sig[SIG_W-1] ? POLY : 0)) ^ zero-extended out_data
  - out_count <= out_count+1, wrapping modulo 2^CNT_W
- sig_clear=1 loads sig=SIG_SEED and out_count=0. It overrides a simultaneous handshake: that word is not folded or counted, but it still leaves the pipe normally.
- Reset (async assert, any time, including mid-transfer):
  - all valid=0, data=0, out_data=0, out_valid=0
  - sig=SIG_SEED, out_count=0
  - in_ready=1 from the first cycle after deassertion
  - in-flight words are discarded.
- in_valid deasserted while in_ready=0: legal; nothing is captured.
- Upstream must hold in_valid and data until accepted.

Test Plan:
- CH=4, DEPTH=2, a=1111 b=1010 c=0011, modes 0..3 in consecutive cycles, out_ready=1 -> out_data 1010,1000,1100,0100 on cycles t+2..t+5.
- Single word mode 0, a=1111 b=1010 from reset -> sig FFFF->EFD5, out_count=1.
- Fill pipe with out_ready=0 -> in_ready=0 after 2 accepts. Then out_ready=1 -> words drain in order, no loss or duplication, 3rd word accepted in the same cycle.
- sig_clear coincident with handshake -> sig=FFFF, out_count=0, word still appears on out_data.
- Assert blif_reset_net mid-stream with 2 words in flight -> out_valid=0, sig=FFFF, out_count=0 immediately. After release the next input emerges exactly DEPTH cycles after acceptance.
- CNT_W=8, 256 transfers -> out_count wraps to 0. Random valid/ready matches a reference-model sequence.
